clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
- Controller and time-base sequencer for the 24-hour BCD clock datapath (hh:mm:ss) that feeds the multiplexed 7-segment display.
- Owns the mode FSM: RUN, SET_HR, SET_MIN.
- Generates the 1 Hz advance, cascades sec→min→hour, applies button-driven field increments, and produces a per-digit blink/blank mask for the display scanner.
- Sits between the debounced push-buttons and the seg7 mux/decoder.

Parameters:
- TICK_CNT, 50000000, clk cycles per one-second advance (≥2).
- BLINK_CNT, 12500000, clk cycles per blink half-period (≥2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  async, active-low reset (0 = reset asserted).
- btn_mode  input  1  debounced, clk-synchronous level; rising edge advances mode.
- btn_inc  input  1  debounced, clk-synchronous level; rising edge increments the selected field.
- hour1, hour0  output  4 each  hour tens/units BCD (00–23).
- min1, min0  output  4 each  minute tens/units BCD (00–59).
- sec1, sec0  output  4 each  second tens/units BCD (00–59).
- blank_mask  output  6  1 = blank digit; bit5..0 = hour1, hour0, min1, min0, sec1, sec0.
- mode  output  2  00 RUN, 01 SET_HR, 10 SET_MIN (11 never driven).
- carry_day  output  1  one-cycle pulse on 23:59:59→00:00:00.

Behaviour:
- Reset (reset=0, async):
  - All BCD outputs 0; mode=RUN; blank_mask=0; carry_day=0.
  - Tick divider and blink counter cleared; blink phase=visible.
  - Button history registers set to 1, so buttons held through reset release do not fire.
- Edge detect:
  - rise = btn & ~btn_prev; btn_prev is updated every clk.
  - The action takes effect at the same clk edge where btn is first sampled 1.
- RUN:
  - Divider counts 0..TICK_CNT-1. At the count TICK_CNT-1 it wraps to 0 and sec advances on that edge.
  - Cascade: sec 59→00 carries to min; min 59→00 carries to hour; hour 23→00.
  - carry_day is registered: high for exactly the cycle after the edge that produces 00:00:00.
  - btn_inc is ignored. blank_mask=000000.
- SET_HR / SET_MIN:
  - Divider frozen; no seconds advance; carry_day=0.
  - btn_inc rise increments only the selected field, wrapping hour 23→00 and min 59→00, with no carry into other fields.
- Mode transitions on btn_mode rise:
  - RUN→SET_HR.
  - SET_HR→SET_MIN.
  - SET_MIN→RUN: sec cleared to 00 and divider cleared on that edge, so the first advance comes exactly TICK_CNT cycles later.
- Blink:
  - The blink counter runs only in set states and toggles phase every BLINK_CNT cycles.
  - Phase is forced to visible and the counter cleared on entering a set state and on every accepted btn_inc rise.
  - Phase blank: SET_HR → blank_mask=110000; SET_MIN → 001100; otherwise 000000.
- Simultaneous btn_mode and btn_inc rise: mode wins and the increment is dropped.
- Reset asserted mid-set or mid-tick: immediate return to the reset state; there are no partial updates.
- BCD units digits never exceed 9. Tens digits never exceed 2 (hour) or 5 (min/sec).

Test Plan (TICK_CNT=4, BLINK_CNT=3):
1. Assert reset=0 with buttons high, then release:
   - All outputs 0.
   - No mode change from the held buttons.
   - sec0 reads 1 after 4 clk, 2 after 8 clk.
2. Rollover:
   - Set 23:59 via SET_HR (23 presses) and SET_MIN (59 presses), then exit to RUN.
   - After 59 ticks the time reads 23:59:59.
   - The next tick gives 00:00:00, with carry_day=1 for exactly one cycle.
3. Wrap in set mode:
   - In SET_HR from 05:30, 19 inc presses → hour 00; min stays 30, sec unchanged.
   - In SET_MIN, 30 presses → min 00; hour unchanged.
4. Blink:
   - Enter SET_HR with no presses: blank_mask 000000 for 3 cycles, 110000 for 3 cycles, repeating.
   - An inc press during blank → 000000 for the following 3 cycles.
   - In SET_MIN the mask is 001100.
5. Exit set:
   - With sec at 42, go RUN→SET_HR→SET_MIN→RUN.
   - sec reads 00 on exit; sec0 reads 1 exactly 4 cycles later.
   - Time does not advance while in set states.
6. Conflicts and reset:
   - Simultaneous mode+inc rise in SET_HR → mode=SET_MIN, hour unchanged.
   - Pulse reset=0 while in SET_MIN at 12:34 → mode=RUN, 00:00:00, blank_mask=0.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Mode FSM, 1 Hz time base and BCD hh:mm:ss register set for a 24-hour clock.
// Buttons set the time field by field; a blink mask drives the display scanner.
module clock_set_ctrl #(
  parameter int TICK_CNT  = 50000000,
  parameter int BLINK_CNT = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] hour1,
  output logic [3:0] hour0,
  output logic [3:0] min1,
  output logic [3:0] min0,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic [5:0] blank_mask,
  output logic [1:0] mode,
  output logic       carry_day
);

  localparam int TW = (TICK_CNT > 2) ? $clog2(TICK_CNT) : 1;
  localparam int BW = (BLINK_CNT > 2) ? $clog2(BLINK_CNT) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CNT - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CNT - 1);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } mode_e;

  mode_e          state, state_nxt;
  logic           mode_prev, inc_prev;
  logic           mode_rise, inc_rise, inc_hit, enter_set, tick;
  logic [TW-1:0]  div_cnt;
  logic [BW-1:0]  blink_cnt;
  logic           blink_phase;
  logic [7:0]     hr, mn, sc;
  logic [7:0]     hr_nxt, mn_nxt, sc_nxt;

  // Two-digit BCD increment that wraps to 00 after the given last value.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last)             return 8'h00;
    else if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    else                       return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign mode_rise = btn_mode & ~mode_prev;
  assign inc_rise  = btn_inc & ~inc_prev;
  assign inc_hit   = inc_rise & ~mode_rise & (state != RUN);
  assign enter_set = mode_rise & (state != SET_MIN);
  assign tick      = (state == RUN) && (div_cnt == TICK_LAST);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    if (mode_rise) begin
      case (state)
        RUN:     state_nxt = SET_HR;
        SET_HR:  state_nxt = SET_MIN;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    hr_nxt = hr;
    mn_nxt = mn;
    sc_nxt = sc;
    case (state)
      RUN: begin
        if (tick) begin
          sc_nxt = bcd_inc(sc, 8'h59);
          if (sc == 8'h59) begin
            mn_nxt = bcd_inc(mn, 8'h59);
            if (mn == 8'h59) hr_nxt = bcd_inc(hr, 8'h23);
          end
        end
      end
      SET_HR: begin
        if (inc_hit) hr_nxt = bcd_inc(hr, 8'h23);
      end
      SET_MIN: begin
        if (mode_rise)    sc_nxt = 8'h00;
        else if (inc_hit) mn_nxt = bcd_inc(mn, 8'h59);
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      mode_prev <= 1'b1;
      inc_prev  <= 1'b1;
      hr        <= 8'h00;
      mn        <= 8'h00;
      sc        <= 8'h00;
      carry_day <= 1'b0;
      div_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      mode_prev <= btn_mode;
      inc_prev  <= btn_inc;
      hr        <= hr_nxt;
      mn        <= mn_nxt;
      sc        <= sc_nxt;
      carry_day <= tick && (hr == 8'h23) && (mn == 8'h59) && (sc == 8'h59);
      if (state == RUN)
        div_cnt <= tick ? '0 : div_cnt + TW'(1);
      else if (state == SET_MIN && mode_rise)
        div_cnt <= '0;
    end
  end

  // Blink runs only while setting; entry and each accepted press restart the visible phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (state_nxt == RUN || enter_set || inc_hit) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + BW'(1);
    end
  end

  always_comb begin
    blank_mask = 6'b000000;
    if (blink_phase) begin
      case (state)
        SET_HR:  blank_mask = 6'b110000;
        SET_MIN: blank_mask = 6'b001100;
        default: blank_mask = 6'b000000;
      endcase
    end
  end

  assign mode  = state;
  assign hour1 = hr[7:4];
  assign hour0 = hr[3:0];
  assign min1  = mn[7:4];
  assign min0  = mn[3:0];
  assign sec1  = sc[7:4];
  assign sec0  = sc[3:0];

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: vector table, directed corner sequences
// and random button traffic, all compared against a seconds-of-day reference model.
module tb_clock_set_ctrl;

  localparam int T = 4;
  localparam int B = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_mode = 1'b1;
  logic       btn_inc = 1'b1;
  logic [3:0] hour1, hour0, min1, min0, sec1, sec0;
  logic [5:0] blank_mask;
  logic [1:0] mode;
  logic       carry_day;

  clock_set_ctrl #(.TICK_CNT(T), .BLINK_CNT(B)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hour1(hour1), .hour0(hour0), .min1(min1), .min0(min0), .sec1(sec1), .sec0(sec0),
    .blank_mask(blank_mask), .mode(mode), .carry_day(carry_day)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time as plain integers, ages as cycle counts since the last restart.
  int m_h, m_m, m_s, m_mode, m_run_age, m_blink_age;
  bit m_pm, m_pi, m_carry;

  typedef struct {
    bit         bm;
    bit         bi;
    logic [1:0] mode;
    logic [3:0] hour0;
    logic [3:0] sec0;
    logic [5:0] mask;
  } vec_t;

  vec_t tbl[24];

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [32:0] dut_vec();
    return {hour1, hour0, min1, min0, sec1, sec0, blank_mask, mode, carry_day};
  endfunction

  function automatic logic [23:0] dut_time();
    return {hour1, hour0, min1, min0, sec1, sec0};
  endfunction

  function automatic logic [32:0] model_vec();
    logic [5:0] mask;
    mask = 6'h00;
    if (m_mode != 0 && ((m_blink_age / B) % 2) == 1)
      mask = (m_mode == 1) ? 6'h30 : 6'h0c;
    return {4'(m_h / 10), 4'(m_h % 10), 4'(m_m / 10), 4'(m_m % 10),
            4'(m_s / 10), 4'(m_s % 10), mask, 2'(m_mode), m_carry};
  endfunction

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_mode = 0;
    m_run_age = 0; m_blink_age = 0;
    m_pm = 1'b1; m_pi = 1'b1; m_carry = 1'b0;
  endtask

  task automatic model_step(input bit bm, input bit bi);
    bit mr, ir;
    int total;
    mr = bm && !m_pm;
    ir = bi && !m_pi;
    m_carry = 1'b0;
    case (m_mode)
      0: begin
        m_run_age++;
        if (m_run_age % T == 0) begin
          total = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
          m_h = total / 3600;
          m_m = (total / 60) % 60;
          m_s = total % 60;
          if (total == 0) m_carry = 1'b1;
        end
        if (mr) begin m_mode = 1; m_blink_age = 0; end
      end
      1: begin
        if (mr)      begin m_mode = 2; m_blink_age = 0; end
        else if (ir) begin m_h = (m_h + 1) % 24; m_blink_age = 0; end
        else         m_blink_age++;
      end
      default: begin
        if (mr)      begin m_mode = 0; m_s = 0; m_run_age = 0; end
        else if (ir) begin m_m = (m_m + 1) % 60; m_blink_age = 0; end
        else         m_blink_age++;
      end
    endcase
    m_pm = bm;
    m_pi = bi;
  endtask

  // One clock: drive, clock, advance model, compare every output.
  task automatic step(input bit bm, input bit bi);
    btn_mode = bm;
    btn_inc  = bi;
    @(posedge clk);
    #1;
    model_step(bm, bi);
    check("cycle", dut_vec(), model_vec());
  endtask

  task automatic press(input bit bm, input bit bi);
    step(bm, bi);
    step(1'b0, 1'b0);
  endtask

  // Buttons held high through reset; reset effect checked before any clock edge.
  task automatic apply_reset();
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    reset    = 1'b0;
    #2;
    check("reset_state", dut_vec(), 33'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 2'd0, 4'd0, 4'd0, 6'h00};
    tbl[1]  = '{1'b1, 1'b1, 2'd0, 4'd0, 4'd0, 6'h00};
    tbl[2]  = '{1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 6'h00};
    tbl[3]  = '{1'b0, 1'b0, 2'd0, 4'd0, 4'd1, 6'h00};
    tbl[4]  = '{1'b0, 1'b1, 2'd0, 4'd0, 4'd1, 6'h00};
    tbl[5]  = '{1'b0, 1'b0, 2'd0, 4'd0, 4'd1, 6'h00};
    tbl[6]  = '{1'b0, 1'b0, 2'd0, 4'd0, 4'd1, 6'h00};
    tbl[7]  = '{1'b0, 1'b0, 2'd0, 4'd0, 4'd2, 6'h00};
    tbl[8]  = '{1'b1, 1'b0, 2'd1, 4'd0, 4'd2, 6'h00};
    tbl[9]  = '{1'b1, 1'b0, 2'd1, 4'd0, 4'd2, 6'h00};
    tbl[10] = '{1'b0, 1'b0, 2'd1, 4'd0, 4'd2, 6'h00};
    tbl[11] = '{1'b0, 1'b0, 2'd1, 4'd0, 4'd2, 6'h30};
    tbl[12] = '{1'b0, 1'b0, 2'd1, 4'd0, 4'd2, 6'h30};
    tbl[13] = '{1'b0, 1'b1, 2'd1, 4'd1, 4'd2, 6'h00};
    tbl[14] = '{1'b0, 1'b0, 2'd1, 4'd1, 4'd2, 6'h00};
    tbl[15] = '{1'b1, 1'b0, 2'd2, 4'd1, 4'd2, 6'h00};
    tbl[16] = '{1'b0, 1'b0, 2'd2, 4'd1, 4'd2, 6'h00};
    tbl[17] = '{1'b0, 1'b0, 2'd2, 4'd1, 4'd2, 6'h00};
    tbl[18] = '{1'b0, 1'b0, 2'd2, 4'd1, 4'd2, 6'h0c};
    tbl[19] = '{1'b1, 1'b1, 2'd0, 4'd1, 4'd0, 6'h00};
    tbl[20] = '{1'b0, 1'b0, 2'd0, 4'd1, 4'd0, 6'h00};
    tbl[21] = '{1'b0, 1'b0, 2'd0, 4'd1, 4'd0, 6'h00};
    tbl[22] = '{1'b0, 1'b0, 2'd0, 4'd1, 4'd0, 6'h00};
    tbl[23] = '{1'b0, 1'b0, 2'd0, 4'd1, 4'd1, 6'h00};

    #1;
    model_reset();
    apply_reset();
    for (int i = 0; i < 24; i++) begin
      step(tbl[i].bm, tbl[i].bi);
      check($sformatf("vec%0d", i), {21'h0, mode, hour0, sec0, blank_mask},
            {21'h0, tbl[i].mode, tbl[i].hour0, tbl[i].sec0, tbl[i].mask});
    end

    // Day rollover from 23:59:00.
    apply_reset();
    step(1'b0, 1'b0);
    press(1'b1, 1'b0);
    repeat (23) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (59) press(1'b0, 1'b1);
    step(1'b1, 1'b0);
    check("set_23_59", {9'h0, dut_time()}, {9'h0, 24'h235900});
    repeat (59 * T) step(1'b0, 1'b0);
    check("pre_rollover", {9'h0, dut_time()}, {9'h0, 24'h235959});
    repeat (T - 1) step(1'b0, 1'b0);
    check("hold_235959", {8'h0, dut_time(), carry_day}, {8'h0, 24'h235959, 1'b0});
    step(1'b0, 1'b0);
    check("rollover", {8'h0, dut_time(), carry_day}, {8'h0, 24'h000000, 1'b1});
    step(1'b0, 1'b0);
    check("carry_one_cycle", {32'h0, carry_day}, 33'h0);

    // Field wrap in set modes from 05:30:03.
    apply_reset();
    step(1'b0, 1'b0);
    press(1'b1, 1'b0);
    repeat (5) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (30) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (3 * T + 1) step(1'b0, 1'b0);
    check("pre_wrap", {9'h0, dut_time()}, {9'h0, 24'h053003});
    press(1'b1, 1'b0);
    repeat (19) press(1'b0, 1'b1);
    check("hour_wrap", {9'h0, dut_time()}, {9'h0, 24'h003003});
    press(1'b1, 1'b0);
    repeat (30) press(1'b0, 1'b1);
    check("min_wrap", {9'h0, dut_time()}, {9'h0, 24'h000003});

    // Simultaneous mode and inc rise in SET_HR.
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("conflict", {23'h0, mode, hour1, hour0}, {23'h0, 2'b10, 8'h00});

    // Exit from set clears seconds and restarts the divider.
    apply_reset();
    step(1'b0, 1'b0);
    repeat (42 * T - 1) step(1'b0, 1'b0);
    check("sec_42", {25'h0, sec1, sec0}, {25'h0, 8'h42});
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    repeat (5 * T) step(1'b0, 1'b0);
    check("frozen", {9'h0, dut_time()}, {9'h0, 24'h000042});
    step(1'b1, 1'b0);
    check("exit_clear", {23'h0, mode, sec1, sec0}, {23'h0, 2'b00, 8'h00});
    repeat (T - 1) step(1'b0, 1'b0);
    check("no_early_tick", {29'h0, sec0}, 33'h0);
    step(1'b0, 1'b0);
    check("first_tick", {29'h0, sec0}, {29'h0, 4'd1});

    // Reset pulse while in SET_MIN at 12:34.
    apply_reset();
    step(1'b0, 1'b0);
    press(1'b1, 1'b0);
    repeat (12) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (34) press(1'b0, 1'b1);
    check("at_12_34", {15'h0, mode, hour1, hour0, min1, min0},
          {15'h0, 2'b10, 16'h1234});
    apply_reset();
    step(1'b0, 1'b0);

    // Random button traffic against the model.
    repeat (3000) step($urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
